// File: rtl/rom_load_pkg.sv
// Shared types and constants for the cart ROM download controller.
// FSM state encoding, mapper codes and address width.
package rom_load_pkg;

  localparam int AW = 25;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    SETTLE,
    COMMIT
  } state_t;

  localparam logic [2:0] MAP_UNKNOWN = 3'd0;
  localparam logic [2:0] MAP_NONE    = 3'd1;
  localparam logic [2:0] MAP_GM2     = 3'd2;
  localparam logic [2:0] MAP_KONAMI  = 3'd3;
  localparam logic [2:0] MAP_KSCC    = 3'd4;
  localparam logic [2:0] MAP_ASCII8  = 3'd5;
  localparam logic [2:0] MAP_ASCII16 = 3'd6;

endpackage

// File: rtl/rom_load_ctrl.sv
// Cart ROM download sequencer: ioctl bytes -> SDRAM write port + detector,
// then settle and commit mapper/offset/size as the cart configuration.
// Ports: clk, reset_n (async low); ioctl_* from HPS with ioctl_wait;
// ram_* SDRAM write port; det_* ROM detector; cart_* committed config;
// overflow (bytes dropped past ROM_MAX), busy (FSM not idle).
// Optional: ROM_MAPPER_OVERRIDE_EN adds ovr_mapper; non-zero wins at commit.
module rom_load_ctrl
  import rom_load_pkg::*;
#(
  parameter logic [AW-1:0] ROM_MAX       = 25'h1000000,
  parameter int            SETTLE_CYCLES = 4,
  parameter logic [AW-1:0] BASE_ADDR     = 25'h0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          dl_active,
  input  logic          ioctl_wr,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic          ioctl_wait,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  output logic          ram_we,
  input  logic          ram_ready,
  output logic          det_clr,
  output logic          det_we,
  output logic [AW-1:0] det_addr,
  output logic [7:0]    det_dout,
  input  logic [2:0]    det_mapper,
`ifdef ROM_MAPPER_OVERRIDE_EN
  input  logic [2:0]    ovr_mapper,
`endif
  input  logic [3:0]    det_offset,
  output logic [2:0]    cart_mapper,
  output logic [3:0]    cart_offset,
  output logic [AW-1:0] cart_size,
  output logic          cart_valid,
  output logic          overflow,
  output logic          busy
);

  state_t        state, nxt;
  logic          dl_prev;
  logic          pend;
  logic [AW-1:0] addr_q;
  logic [3:0]    settle_q;
  logic [AW-1:0] count;

  logic          rise;
  logic          start;
  logic          take;
  logic          in_rng;
  logic          done;
  logic [AW-1:0] sum;
  logic [AW-1:0] cnt_new;
  logic [2:0]    map_sel;

  assign busy = (state != IDLE);

`ifdef ROM_MAPPER_OVERRIDE_EN
  assign map_sel = (ovr_mapper != MAP_UNKNOWN) ? ovr_mapper : det_mapper;
`else
  assign map_sel = det_mapper;
`endif

  always_comb begin
    rise    = dl_active & ~dl_prev;
    start   = (state == IDLE) && (rise || pend);
    take    = (state == LOAD) && ioctl_wr;
    in_rng  = ioctl_addr < ROM_MAX;
    done    = (state == WRITE) && ram_ready;
    sum     = addr_q + 1'b1;
    cnt_new = (sum > count) ? sum : count;
    if (cnt_new > ROM_MAX) cnt_new = ROM_MAX;
    nxt = state;
    unique case (state)
      IDLE:   if (rise || pend) nxt = LOAD;
      LOAD: begin
        if (ioctl_wr) begin
          if (in_rng) nxt = WRITE;
        end else if (!dl_active) begin
          nxt = SETTLE;
        end
      end
      WRITE:  if (ram_ready) nxt = dl_active ? LOAD : SETTLE;
      SETTLE: if (settle_q == 4'd0) nxt = COMMIT;
      COMMIT: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dl_prev     <= 1'b0;
      pend        <= 1'b0;
      addr_q      <= '0;
      settle_q    <= '0;
      count       <= '0;
      ioctl_wait  <= 1'b0;
      ram_addr    <= '0;
      ram_din     <= '0;
      ram_we      <= 1'b0;
      det_clr     <= 1'b0;
      det_we      <= 1'b0;
      det_addr    <= '0;
      det_dout    <= '0;
      cart_mapper <= '0;
      cart_offset <= '0;
      cart_size   <= '0;
      cart_valid  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      dl_prev <= dl_active;
      det_clr <= 1'b0;
      det_we  <= 1'b0;
      // a restart seen before commit is replayed once back in IDLE
      if ((state == SETTLE || state == COMMIT) && rise) pend <= 1'b1;
      if (start) begin
        det_clr    <= 1'b1;
        cart_valid <= 1'b0;
        overflow   <= 1'b0;
        count      <= '0;
        pend       <= 1'b0;
      end
      if (take) begin
        if (in_rng) begin
          addr_q     <= ioctl_addr;
          ram_addr   <= BASE_ADDR + ioctl_addr;
          ram_din    <= ioctl_dout;
          ram_we     <= 1'b1;
          ioctl_wait <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end
      if (done) begin
        ram_we     <= 1'b0;
        ioctl_wait <= 1'b0;
        det_we     <= 1'b1;
        det_addr   <= addr_q;
        det_dout   <= ram_din;
        count      <= cnt_new;
      end
      if (nxt == SETTLE && state != SETTLE)
        settle_q <= 4'(SETTLE_CYCLES - 1);
      else if (state == SETTLE && settle_q != 4'd0)
        settle_q <= settle_q - 4'd1;
      if (state == COMMIT) begin
        cart_size   <= count;
        cart_mapper <= map_sel;
        cart_offset <= det_offset;
        cart_valid  <= (count != '0);
      end
    end
  end

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Directed bench for rom_load_ctrl with a write/detector scoreboard.
// Define ROM_MAPPER_OVERRIDE_EN to also exercise the mapper override.
module tb_rom_load_ctrl;

  localparam logic [24:0] RMAX = 25'h400;
  localparam logic [24:0] BASE = 25'h1FFFF00;

  logic        clk;
  logic        reset_n;
  logic        dl_active;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [24:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic        ram_ready;
  logic        det_clr;
  logic        det_we;
  logic [24:0] det_addr;
  logic [7:0]  det_dout;
  logic [2:0]  det_mapper;
  logic [3:0]  det_offset;
  logic [2:0]  cart_mapper;
  logic [3:0]  cart_offset;
  logic [24:0] cart_size;
  logic        cart_valid;
  logic        overflow;
  logic        busy;
`ifdef ROM_MAPPER_OVERRIDE_EN
  logic [2:0]  ovr_mapper;
`endif

  rom_load_ctrl #(
    .ROM_MAX(RMAX),
    .SETTLE_CYCLES(4),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .dl_active(dl_active),
    .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait),
    .ram_addr(ram_addr),
    .ram_din(ram_din),
    .ram_we(ram_we),
    .ram_ready(ram_ready),
    .det_clr(det_clr),
    .det_we(det_we),
    .det_addr(det_addr),
    .det_dout(det_dout),
    .det_mapper(det_mapper),
`ifdef ROM_MAPPER_OVERRIDE_EN
    .ovr_mapper(ovr_mapper),
`endif
    .det_offset(det_offset),
    .cart_mapper(cart_mapper),
    .cart_offset(cart_offset),
    .cart_size(cart_size),
    .cart_valid(cart_valid),
    .overflow(overflow),
    .busy(busy)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rdy_lat = 2;
  int wcnt = 0;
  int nwr = 0;
  int ndet = 0;
  int nclr = 0;
  int last_det = 0;
  logic [32:0] wq[$];
  logic [32:0] dq[$];
  logic [32:0] we_e;
  logic [32:0] de_e;
  logic [24:0] ea;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // SDRAM arbiter model: pulses ram_ready rdy_lat cycles into a request
  always @(negedge clk) begin
    if (!ram_we) begin
      wcnt = 0;
      ram_ready = 1'b0;
    end else if (!ram_ready) begin
      wcnt++;
      if (wcnt >= rdy_lat) begin
        ram_ready = 1'b1;
        nwr++;
        if (wq.size() == 0) begin
          chk("ram_unexpected", 32'(ram_addr), 32'hFFFFFFFF);
        end else begin
          we_e = wq.pop_front();
          ea = BASE + we_e[32:8];
          chk("ram_addr", 32'(ram_addr), 32'(ea));
          chk("ram_din", 32'(ram_din), 32'(we_e[7:0]));
        end
      end
    end else begin
      ram_ready = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (det_clr) nclr++;
    if (det_we) begin
      ndet++;
      last_det = cyc;
      if (dq.size() == 0) begin
        chk("det_unexpected", 32'(det_addr), 32'hFFFFFFFF);
      end else begin
        de_e = dq.pop_front();
        chk("det_addr", 32'(det_addr), 32'(de_e[32:8]));
        chk("det_dout", 32'(det_dout), 32'(de_e[7:0]));
      end
    end
  end

  task automatic send(input logic [24:0] a, input logic [7:0] d,
                      input bit last);
    int n;
    n = 0;
    while (ioctl_wait && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("wait_timeout", 32'(ioctl_wait), 32'h0);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    if (a < RMAX) begin
      wq.push_back({a, d});
      dq.push_back({a, d});
    end
    @(negedge clk);
    ioctl_wr = 1'b0;
    if (last) dl_active = 1'b0;
    if (a >= RMAX) chk("drop_nowait", 32'(ioctl_wait), 32'h0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk(tag, 32'(busy), 32'h0);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!cart_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk(tag, 32'(cart_valid), 32'h1);
  endtask

  int w0, d0, c0;

  initial begin
    reset_n = 1'b0;
    dl_active = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    ram_ready = 1'b0;
    det_mapper = 3'd0;
    det_offset = 4'd0;
`ifdef ROM_MAPPER_OVERRIDE_EN
    ovr_mapper = 3'd0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_wait", 32'(ioctl_wait), 32'h0);
    chk("rst_we", 32'(ram_we), 32'h0);
    chk("rst_detwe", 32'(det_we), 32'h0);
    chk("rst_detclr", 32'(det_clr), 32'h0);
    chk("rst_valid", 32'(cart_valid), 32'h0);
    chk("rst_size", 32'(cart_size), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: 0x300-byte image, latency from last det_we to cart_valid
    w0 = nwr; d0 = ndet; c0 = nclr;
    det_mapper = 3'd1;
    det_offset = 4'd4;
    dl_active = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 'h300; i++) begin
      logic [24:0] a;
      a = 25'(i);
      send(a, a[7:0] ^ 8'hA5, i == 'h2FF);
    end
    wait_valid("t1_valid_to");
    chk("t1_latency", 32'(cyc - last_det), 32'd5);
    wait_idle("t1_idle_to");
    chk("t1_size", 32'(cart_size), 32'h300);
    chk("t1_mapper", 32'(cart_mapper), 32'd1);
    chk("t1_offset", 32'(cart_offset), 32'd4);
    chk("t1_valid", 32'(cart_valid), 32'h1);
    chk("t1_ovf", 32'(overflow), 32'h0);
    chk("t1_nwr", 32'(nwr - w0), 32'h300);
    chk("t1_ndet", 32'(ndet - d0), 32'h300);
    chk("t1_nclr", 32'(nclr - c0), 32'h1);
    chk("t1_qempty", 32'(wq.size() + dq.size()), 32'h0);

    // 2: image larger than ROM_MAX, tail dropped, size saturates
    w0 = nwr; d0 = ndet;
    det_mapper = 3'd2;
    det_offset = 4'd0;
    dl_active = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 'h600; i++) begin
      logic [24:0] a;
      a = 25'(i);
      send(a, a[7:0] + 8'h3, i == 'h5FF);
    end
    wait_idle("t2_idle_to");
    chk("t2_ovf", 32'(overflow), 32'h1);
    chk("t2_size", 32'(cart_size), 32'(RMAX));
    chk("t2_valid", 32'(cart_valid), 32'h1);
    chk("t2_mapper", 32'(cart_mapper), 32'd2);
    chk("t2_nwr", 32'(nwr - w0), 32'h400);
    chk("t2_ndet", 32'(ndet - d0), 32'h400);

    // 3: empty download
    c0 = nclr; d0 = ndet;
    det_mapper = 3'd5;
    det_offset = 4'd2;
    dl_active = 1'b1;
    @(negedge clk);
    dl_active = 1'b0;
    @(negedge clk);
    wait_idle("t3_idle_to");
    chk("t3_nclr", 32'(nclr - c0), 32'h1);
    chk("t3_valid", 32'(cart_valid), 32'h0);
    chk("t3_size", 32'(cart_size), 32'h0);
    chk("t3_mapper", 32'(cart_mapper), 32'd5);
    chk("t3_offset", 32'(cart_offset), 32'd2);
    chk("t3_ovf", 32'(overflow), 32'h0);
    chk("t3_ndet", 32'(ndet - d0), 32'h0);

    // 4: dl_active falls during a stalled write; stray wr while waiting
    w0 = nwr; d0 = ndet;
    det_mapper = 3'd3;
    dl_active = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) send(25'(i + 'h20), 8'(i + 'h70), 1'b0);
    while (ioctl_wait) @(negedge clk);
    rdy_lat = 10;
    send(25'h23, 8'h99, 1'b1);
    chk("t4_wait_hi", 32'(ioctl_wait), 32'h1);
    ioctl_addr = 25'h10;
    ioctl_dout = 8'hEE;
    ioctl_wr = 1'b1;
    @(negedge clk);
    ioctl_wr = 1'b0;
    chk("t4_we_held", 32'(ram_we), 32'h1);
    wait_idle("t4_idle_to");
    rdy_lat = 2;
    chk("t4_nwr", 32'(nwr - w0), 32'd4);
    chk("t4_ndet", 32'(ndet - d0), 32'd4);
    chk("t4_size", 32'(cart_size), 32'h24);
    chk("t4_valid", 32'(cart_valid), 32'h1);
    chk("t4_mapper", 32'(cart_mapper), 32'd3);

    // 5: async reset while a write is outstanding
    rdy_lat = 1000;
    dl_active = 1'b1;
    @(negedge clk);
    send(25'h0, 8'h11, 1'b0);
    @(negedge clk);
    chk("t5_we_pre", 32'(ram_we), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_we", 32'(ram_we), 32'h0);
    chk("t5_wait", 32'(ioctl_wait), 32'h0);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_valid", 32'(cart_valid), 32'h0);
    wq.delete();
    dq.delete();
    dl_active = 1'b0;
    @(negedge clk);
    rdy_lat = 2;
    reset_n = 1'b1;
    @(negedge clk);
    w0 = nwr; d0 = ndet;
    det_mapper = 3'd6;
    det_offset = 4'd1;
    dl_active = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) send(25'(i), 8'(i * 7), i == 15);
    wait_idle("t5_idle_to");
    chk("t5_size", 32'(cart_size), 32'd16);
    chk("t5_cvalid", 32'(cart_valid), 32'h1);
    chk("t5_mapper", 32'(cart_mapper), 32'd6);
    chk("t5_offset", 32'(cart_offset), 32'd1);
    chk("t5_nwr", 32'(nwr - w0), 32'd16);
    chk("t5_ndet", 32'(ndet - d0), 32'd16);

`ifdef ROM_MAPPER_OVERRIDE_EN
    // 6: override mapper
    det_mapper = 3'd6;
    ovr_mapper = 3'd3;
    dl_active = 1'b1;
    @(negedge clk);
    send(25'h0, 8'h42, 1'b1);
    wait_idle("t6a_idle_to");
    chk("t6a_mapper", 32'(cart_mapper), 32'd3);
    ovr_mapper = 3'd0;
    dl_active = 1'b1;
    @(negedge clk);
    send(25'h0, 8'h43, 1'b1);
    wait_idle("t6b_idle_to");
    chk("t6b_mapper", 32'(cart_mapper), 32'd6);
`endif

    repeat (3) @(negedge clk);
    chk("end_qempty", 32'(wq.size() + dq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_load_ctrl.md
Name: rom_load_ctrl

Overview:
- Sequences a cartridge ROM download from the ioctl stream into the cart SDRAM write port.
- Mirrors every accepted byte to the ROM-detector strobe interface and, after the download ends, waits for the detector outputs to settle.
- Commits mapper, offset and size into registered cart configuration read by the slot/mapper logic.
- Sits between the HPS ioctl interface, the SDRAM arbiter write port and the ROM detector.

Parameters:
- ROM_MAX, 25'h1000000: byte capacity of the cart region. Writes at or above it are dropped.
- SETTLE_CYCLES, 4: clk cycles to wait after the last detector strobe before commit (1..15).
- BASE_ADDR, 25'h0: SDRAM byte base added to the ioctl address.

Ports:
- clk in 1: system clock.
- reset_n in 1: asynchronous active-low reset.
- dl_active in 1: ROM download in progress (ioctl download AND ROM index).
- ioctl_wr in 1: byte-valid strobe from HPS.
- ioctl_addr in 25: byte address within the download.
- ioctl_dout in 8: byte data.
- ioctl_wait out 1: back-pressure to HPS.
- ram_addr out 25: SDRAM byte address.
- ram_din out 8: SDRAM write data.
- ram_we out 1: write request, held until ram_ready.
- ram_ready in 1: write accepted (single-cycle pulse).
- det_clr out 1: one-cycle pulse clearing detector state at download start.
- det_we out 1: one-cycle strobe per accepted byte.
- det_addr out 25: address that goes with det_we.
- det_dout out 8: data that goes with det_we.
- det_mapper in 3: detector mapper result.
- det_offset in 4: detector offset result.
- cart_mapper out 3: committed mapper (0 unknown … 6 ASCII16).
- cart_offset out 4: committed start-page offset.
- cart_size out 25: committed byte count.
- cart_valid out 1: configuration committed and non-empty.
- overflow out 1: at least one byte was dropped beyond ROM_MAX.
- busy out 1: FSM not in IDLE.

Behaviour:
- Reset: all outputs 0. FSM enters IDLE. The byte counter is cleared.
- States:
  - IDLE: on the dl_active rising edge, pulse det_clr, clear cart_valid, overflow and count, then go to LOAD.
  - LOAD: on ioctl_wr, capture addr/data and set ioctl_wait the next cycle.
    - If addr < ROM_MAX, go to WRITE.
    - Otherwise set overflow, keep ioctl_wait low and stay in LOAD; the byte is dropped.
    - On dl_active low with no ioctl_wr, go to SETTLE.
  - WRITE: ram_we=1, ram_addr=BASE_ADDR+addr, ram_din=data, all held stable.
    - On ram_ready: drop ram_we the next cycle, pulse det_we/det_addr/det_dout for one cycle, set count=max(count, addr+1), drop ioctl_wait, and return to LOAD.
  - SETTLE: count down SETTLE_CYCLES, then go to COMMIT.
  - COMMIT: one cycle.
    - cart_size<=count, cart_mapper<=det_mapper, cart_offset<=det_offset, cart_valid<=(count!=0).
    - Return to IDLE.
- Latency: ioctl_wr to ram_we is 1 cycle. ram_ready to det_we is 1 cycle. Last det_we to cart_valid is SETTLE_CYCLES+1 cycles.
- ioctl_wr while ioctl_wait=1 is a protocol violation: the byte is ignored with no state change.
- dl_active falling during WRITE: the write completes, then the FSM goes to SETTLE; it does not return to LOAD.
- dl_active rising again before COMMIT: treated as a new download only after the FSM returns to IDLE. A rise seen in SETTLE/COMMIT is remembered (one-bit pending flag) and starts LOAD immediately after COMMIT.
- Empty download (no bytes): cart_valid=0, cart_size=0, mapper/offset still latched.
- Address arithmetic is modulo 2^25. Count saturates at ROM_MAX.
- Async reset mid-WRITE aborts: ram_we drops immediately, and the SDRAM arbiter must tolerate the dropped request.

Optional Feature:
- Macro: ROM_MAPPER_OVERRIDE_EN.
- Enabled: adds input ovr_mapper[2:0]. In COMMIT, a non-zero ovr_mapper replaces det_mapper, and det_offset is still used.
- Disabled: the port is absent and det_mapper is always committed.

Decomposition:
- Package rom_load_pkg: FSM state enum (IDLE, LOAD, WRITE, SETTLE, COMMIT), mapper code constants (MAP_UNKNOWN=0, MAP_NONE=1, MAP_GM2=2, MAP_KONAMI=3, MAP_KSCC=4, MAP_ASCII8=5, MAP_ASCII16=6), address width constant 25.
- No sub-module; a single FSM with a settle counter is natural.

Test Plan:
- 0x8000-byte download, ram_ready 2 cycles after each ram_we, det_mapper=1, det_offset=4 → 0x8000 SDRAM writes, 0x8000 det_we pulses, cart_size=0x8000, cart_mapper=1, cart_offset=4, cart_valid=1 exactly 5 cycles after the last det_we.
- ROM_MAX=0x4000, 0x6000-byte download → writes stop at 0x3FFF, overflow=1, cart_size=0x4000, ioctl_wait never asserted for the dropped bytes.
- dl_active pulses with no ioctl_wr → det_clr pulsed once, cart_valid=0, cart_size=0.
- dl_active falls while ram_ready is held off for 10 cycles in WRITE → write completes, one final det_we, then SETTLE and COMMIT.
- reset_n asserted mid-WRITE → ram_we, ioctl_wait, busy and cart_valid go 0 immediately. A new download afterwards commits correctly.
- With ROM_MAPPER_OVERRIDE_EN and ovr_mapper=3, det_mapper=6 → cart_mapper=3. With ovr_mapper=0 → cart_mapper=6.
